// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: shared definitions for the MEM pipeline stage.
//   - instruction ids decoded by the stage (memory ops, NOP and a generic ALU op)
//   - field widths for instruction id, data word, byte address and register index
//   - reset / write-strobe polarity constants
//   - MEM FSM state encoding
//   - helpers that classify an instruction id and return its access size
package mem_stage_pkg;

  localparam int INST_IDX_W = 4;   // instruction id width
  localparam int DATA_W     = 32;  // data word width
  localparam int MEM_ADDR_W = 32;  // effective address width from EX
  localparam int REG_IDX_W  = 5;   // register index width

  localparam logic RST_ENABLE    = 1'b1;
  localparam logic WRITE_DISABLE = 1'b0;

  localparam logic [INST_IDX_W-1:0] idNOP = 4'd0;
  localparam logic [INST_IDX_W-1:0] idLB  = 4'd1;
  localparam logic [INST_IDX_W-1:0] idLH  = 4'd2;
  localparam logic [INST_IDX_W-1:0] idLW  = 4'd3;
  localparam logic [INST_IDX_W-1:0] idLBU = 4'd4;
  localparam logic [INST_IDX_W-1:0] idLHU = 4'd5;
  localparam logic [INST_IDX_W-1:0] idSB  = 4'd6;
  localparam logic [INST_IDX_W-1:0] idSH  = 4'd7;
  localparam logic [INST_IDX_W-1:0] idSW  = 4'd8;
  localparam logic [INST_IDX_W-1:0] idADD = 4'd9;

  typedef enum logic [1:0] {
    MEM_IDLE = 2'd0,
    MEM_BUSY = 2'd1,
    MEM_DONE = 2'd2
  } mem_state_e;

  function automatic logic is_load(input logic [INST_IDX_W-1:0] id);
    return (id == idLB) || (id == idLH) || (id == idLW) ||
           (id == idLBU) || (id == idLHU);
  endfunction

  function automatic logic is_store(input logic [INST_IDX_W-1:0] id);
    return (id == idSB) || (id == idSH) || (id == idSW);
  endfunction

  // Number of bytes moved by the access; 0 for non-memory instructions.
  function automatic logic [2:0] access_size(input logic [INST_IDX_W-1:0] id);
    logic [2:0] n;
    case (id)
      idLB, idLBU, idSB: n = 3'd1;
      idLH, idLHU, idSH: n = 3'd2;
      idLW, idSW:        n = 3'd4;
      default:           n = 3'd0;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/mem_stage_load_ext.sv
// mem_load_ext: combinational load-data extension.
// Ports:
//   ld_buf_in   - assembled load bytes, byte 0 in [7:0]
//   inst_idx_in - load instruction id selecting width and signedness
//   ext_out     - 32-bit writeback word (0 for non-load ids)
module mem_load_ext
  import mem_stage_pkg::*;
(
  input  logic [DATA_W-1:0]     ld_buf_in,
  input  logic [INST_IDX_W-1:0] inst_idx_in,
  output logic [DATA_W-1:0]     ext_out
);

  function automatic logic [DATA_W-1:0] sext8(input logic signed [7:0] b);
    logic signed [DATA_W-1:0] w;
    w = DATA_W'(b);
    return w;
  endfunction

  function automatic logic [DATA_W-1:0] sext16(input logic signed [15:0] h);
    logic signed [DATA_W-1:0] w;
    w = DATA_W'(h);
    return w;
  endfunction

  always_comb begin
    ext_out = '0;
    case (inst_idx_in)
      idLB:    ext_out = sext8(ld_buf_in[7:0]);
      idLH:    ext_out = sext16(ld_buf_in[15:0]);
      idLBU:   ext_out = {24'd0, ld_buf_in[7:0]};
      idLHU:   ext_out = {16'd0, ld_buf_in[15:0]};
      idLW:    ext_out = ld_buf_in;
      default: ext_out = '0;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// mem_stage: MEM pipeline stage. Runs loads/stores one byte per cycle over a
// shared byte-wide RAM port and forwards writeback fields to MEM/WB.
// Ports:
//   clk_in, rst_in (async, active-high)
//   instIdx_in, memAddr_in, valStore_in, rdE_in, rdIdx_in, rdData_in - EX/MEM
//   memBusy_in   - RAM port granted to IF this cycle (no issue possible)
//   mem_din_in   - RAM read data for the address issued last cycle
//   mem_a_out, mem_dout_out, mem_wr_out - RAM byte port
//   stallReq_out - holds EX/MEM and upstream while an access is in flight
//   rdE_out, rdIdx_out, rdData_out      - MEM/WB writeback fields
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int RD_LAT = 1
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic [INST_IDX_W-1:0] instIdx_in,
  input  logic [MEM_ADDR_W-1:0] memAddr_in,
  input  logic [DATA_W-1:0]     valStore_in,
  input  logic                  rdE_in,
  input  logic [REG_IDX_W-1:0]  rdIdx_in,
  input  logic [DATA_W-1:0]     rdData_in,
  input  logic                  memBusy_in,
  input  logic [7:0]            mem_din_in,
  output logic [ADDR_W-1:0]     mem_a_out,
  output logic [7:0]            mem_dout_out,
  output logic                  mem_wr_out,
  output logic                  stallReq_out,
  output logic                  rdE_out,
  output logic [REG_IDX_W-1:0]  rdIdx_out,
  output logic [DATA_W-1:0]     rdData_out
);

  // The capture logic assumes read data arrives exactly one cycle after issue.
  if (RD_LAT != 1) begin : g_rd_lat_check
    $error("mem_stage supports RD_LAT == 1 only");
  end

  mem_state_e        state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic              pending_q, pending_d;
  logic [DATA_W-1:0] buf_q, buf_d;

  logic [2:0]        n_bytes;
  logic              op_load, op_store, op_mem, issue, finished;
  logic [DATA_W-1:0] ext_word;

  assign n_bytes  = access_size(instIdx_in);
  assign op_load  = is_load(instIdx_in);
  assign op_store = is_store(instIdx_in);
  assign op_mem   = op_load | op_store;
  assign issue    = !rst_in && op_mem && (state_q != MEM_DONE) &&
                    !memBusy_in && (cnt_q < n_bytes);

  mem_load_ext u_load_ext (
    .ld_buf_in   (buf_q),
    .inst_idx_in (instIdx_in),
    .ext_out     (ext_word)
  );

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in == RST_ENABLE) begin
      state_q   <= MEM_IDLE;
      cnt_q     <= 3'd0;
      pending_q <= 1'b0;
      buf_q     <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pending_q <= pending_d;
      buf_q     <= buf_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pending_d = 1'b0;
    buf_d     = buf_q;

    // Read data returning now belongs to byte cnt-1 (cnt already advanced at
    // issue); it is captured even when IF owns the port this cycle.
    if (pending_q) begin
      case (cnt_q)
        3'd1:    buf_d[7:0]   = mem_din_in;
        3'd2:    buf_d[15:8]  = mem_din_in;
        3'd3:    buf_d[23:16] = mem_din_in;
        3'd4:    buf_d[31:24] = mem_din_in;
        default: buf_d        = buf_q;
      endcase
    end

    if (issue) begin
      cnt_d     = cnt_q + 3'd1;
      pending_d = op_load;
    end

    // Leave for DONE as soon as the last byte is issued (store) or captured
    // (load), so DONE follows the final stall cycle directly.
    finished = (cnt_d == n_bytes) && !pending_d;

    case (state_q)
      MEM_IDLE: if (op_mem) state_d = finished ? MEM_DONE : MEM_BUSY;
      MEM_BUSY: if (finished) state_d = MEM_DONE;
      MEM_DONE: begin
        state_d   = MEM_IDLE;
        cnt_d     = 3'd0;
        pending_d = 1'b0;
      end
      default:  state_d = MEM_IDLE;
    endcase
  end

  always_comb begin
    mem_a_out    = '0;
    mem_dout_out = 8'd0;
    mem_wr_out   = WRITE_DISABLE;
    stallReq_out = 1'b0;
    rdE_out      = 1'b0;
    rdIdx_out    = '0;
    rdData_out   = '0;

    if (!rst_in) begin
      if (!op_mem) begin
        rdE_out    = rdE_in;
        rdIdx_out  = rdIdx_in;
        rdData_out = rdData_in;
      end else if (state_q == MEM_DONE) begin
        rdE_out    = op_load & rdE_in;
        rdIdx_out  = rdIdx_in;
        rdData_out = op_load ? ext_word : '0;
      end else begin
        stallReq_out = 1'b1;
      end

      if (issue) begin
        mem_a_out = ADDR_W'(memAddr_in) + ADDR_W'(cnt_q);
        if (op_store) begin
          mem_wr_out = 1'b1;
          case (cnt_q[1:0])
            2'd0: mem_dout_out = valStore_in[7:0];
            2'd1: mem_dout_out = valStore_in[15:8];
            2'd2: mem_dout_out = valStore_in[23:16];
            2'd3: mem_dout_out = valStore_in[31:24];
            default: mem_dout_out = 8'd0;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;
  import mem_stage_pkg::*;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic [3:0]  instIdx_in;
  logic [31:0] memAddr_in, valStore_in, rdData_in;
  logic        rdE_in, memBusy_in;
  logic [4:0]  rdIdx_in;
  logic [7:0]  mem_din_in;
  logic [31:0] mem_a_out;
  logic [7:0]  mem_dout_out;
  logic        mem_wr_out, stallReq_out, rdE_out;
  logic [4:0]  rdIdx_out;
  logic [31:0] rdData_out;

  int compared = 0;
  int mismatched = 0;

  always #5 clk_in = ~clk_in;

  mem_stage #(.ADDR_W(32), .RD_LAT(1)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .instIdx_in(instIdx_in),
    .memAddr_in(memAddr_in), .valStore_in(valStore_in), .rdE_in(rdE_in),
    .rdIdx_in(rdIdx_in), .rdData_in(rdData_in), .memBusy_in(memBusy_in),
    .mem_din_in(mem_din_in), .mem_a_out(mem_a_out), .mem_dout_out(mem_dout_out),
    .mem_wr_out(mem_wr_out), .stallReq_out(stallReq_out), .rdE_out(rdE_out),
    .rdIdx_out(rdIdx_out), .rdData_out(rdData_out)
  );

  // ---------------- RAM model (1 KiB, 1-cycle read latency) ----------------
  logic [7:0]  ram [1024];
  logic        ram_ready = 1'b0;
  logic        pl_en = 1'b0;
  logic [9:0]  pl_a = '0;
  logic [7:0]  pl_d = '0;
  logic [31:0] wlog_a [64];
  logic [7:0]  wlog_d [64];
  int          wcnt = 0;

  function automatic logic [7:0] init_byte(input int i);
    return 8'((i * 37 + 5) & 255);
  endfunction

  always @(posedge clk_in) begin
    if (!ram_ready) begin
      for (int i = 0; i < 1024; i++) ram[i] <= init_byte(i);
      ram_ready <= 1'b1;
    end else if (pl_en) begin
      ram[pl_a] <= pl_d;
    end else if (mem_wr_out) begin
      ram[mem_a_out[9:0]] <= mem_dout_out;
      wlog_a[wcnt % 64]   <= mem_a_out;
      wlog_d[wcnt % 64]   <= mem_dout_out;
      wcnt                <= wcnt + 1;
    end
    mem_din_in <= ram[mem_a_out[9:0]];
  end

  // ---------------- reference model ----------------
  logic [7:0] ref_ram [1024];

  function automatic int nbytes(input logic [3:0] op);
    if (op == idLB || op == idLBU || op == idSB) return 1;
    if (op == idLH || op == idLHU || op == idSH) return 2;
    if (op == idLW || op == idSW) return 4;
    return 0;
  endfunction

  function automatic bit loads(input logic [3:0] op);
    return op == idLB || op == idLH || op == idLW || op == idLBU || op == idLHU;
  endfunction

  function automatic bit stores(input logic [3:0] op);
    return op == idSB || op == idSH || op == idSW;
  endfunction

  // Stall cycles: one per byte issued, one per arbiter-busy cycle before the
  // last byte goes out, plus one trailing cycle for load data to return.
  function automatic int model_stalls(input logic [3:0] op, input logic [15:0] busy);
    int n, c, issued;
    n = nbytes(op);
    if (n == 0) return 0;
    c = 0; issued = 0;
    while (issued < n) begin
      if (!(c < 16 && busy[c])) issued++;
      c++;
    end
    return c + (loads(op) ? 1 : 0);
  endfunction

  function automatic logic [31:0] model_load(input logic [3:0] op, input logic [31:0] addr);
    longint raw;
    logic [31:0] a;
    int n;
    n = nbytes(op);
    raw = 0;
    for (int i = 0; i < n; i++) begin
      a = addr + 32'(i);
      raw = raw + (longint'(ref_ram[a[9:0]]) << (8 * i));
    end
    if ((op == idLB || op == idLH) && raw >= (64'sd1 << (8 * n - 1)))
      raw = raw - (64'sd1 << (8 * n));
    return 32'(raw);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic preload(input logic [9:0] a, input logic [7:0] d);
    pl_a = a; pl_d = d; pl_en = 1'b1;
    @(posedge clk_in); #1;
    pl_en = 1'b0;
    ref_ram[a] = d;
  endtask

  // Apply one instruction (entered at posedge+1) and run it to its DONE /
  // pass-through cycle; checks stall length, writeback fields and RAM writes.
  task automatic run_op(input string name, input logic [3:0] op, input logic [31:0] addr,
                        input logic [31:0] val, input logic [15:0] busy, input logic rde,
                        input logic [4:0] idx, input logic [31:0] rdd, input int exp_stall,
                        input logic exp_e, input logic [31:0] exp_data);
    int stalls, w0, n;
    bit done;
    logic [31:0] got_d, ea;
    logic got_e;
    logic [4:0] got_i;
    instIdx_in = op; memAddr_in = addr; valStore_in = val;
    rdE_in = rde; rdIdx_in = idx; rdData_in = rdd;
    stalls = 0; done = 0; w0 = wcnt;
    got_d = '0; got_e = 1'b0; got_i = '0;
    for (int c = 0; c < 40 && !done; c++) begin
      memBusy_in = (c < 16) ? busy[c] : 1'b0;
      #4;
      if (stallReq_out) begin
        stalls++;
        if (memBusy_in) chk({name, ".busy_quiet"}, {31'd0, mem_wr_out} | mem_a_out, 32'd0);
      end else begin
        done = 1; got_d = rdData_out; got_e = rdE_out; got_i = rdIdx_out;
      end
      @(posedge clk_in); #1;
    end
    memBusy_in = 1'b0;
    if (!done) chk({name, ".timeout"}, 32'd1, 32'd0);
    chk({name, ".stalls"}, 32'(stalls), 32'(exp_stall));
    chk({name, ".rdE"}, {31'd0, got_e}, {31'd0, exp_e});
    chk({name, ".rdIdx"}, {27'd0, got_i}, {27'd0, idx});
    chk({name, ".rdData"}, got_d, exp_data);
    n = stores(op) ? nbytes(op) : 0;
    chk({name, ".nwrites"}, 32'(wcnt - w0), 32'(n));
    for (int i = 0; i < n && (wcnt - w0) == n; i++) begin
      ea = addr + 32'(i);
      chk({name, ".waddr"}, wlog_a[(w0 + i) % 64], ea);
      chk({name, ".wdata"}, {24'd0, wlog_d[(w0 + i) % 64]}, (val >> (8 * i)) & 32'hFF);
      ref_ram[ea[9:0]] = 8'((val >> (8 * i)) & 32'hFF);
    end
  endtask

  typedef struct {
    string       name;
    logic [3:0]  op;
    logic [31:0] addr;
    logic [31:0] val;
    logic [15:0] busy;
    logic [4:0]  idx;
    int          exp_stall;
    logic        exp_e;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vecs [9];
  logic [3:0] ops [10];

  initial begin
    for (int i = 0; i < 1024; i++) ref_ram[i] = init_byte(i);
    ops = '{idLB, idLH, idLW, idLBU, idLHU, idSB, idSH, idSW, idADD, idNOP};

    vecs[0] = '{"add",  idADD, 32'h0,        32'h1234,     16'h0,    5'd5, 0, 1'b1, 32'h1234};
    vecs[1] = '{"sw",   idSW,  32'h100,      32'hAABBCCDD, 16'h0,    5'd6, 4, 1'b0, 32'h0};
    vecs[2] = '{"lb",   idLB,  32'h7,        32'h0,        16'h0,    5'd7, 2, 1'b1, 32'hFFFFFF80};
    vecs[3] = '{"lbu",  idLBU, 32'h7,        32'h0,        16'h0,    5'd8, 2, 1'b1, 32'h00000080};
    vecs[4] = '{"lw",   idLW,  32'h201,      32'h0,        16'h0004, 5'd9, 6, 1'b1, 32'h44332211};
    vecs[5] = '{"sb",   idSB,  32'h10,       32'h5A,       16'h0,    5'd10, 1, 1'b0, 32'h0};
    vecs[6] = '{"lhu",  idLHU, 32'h10,       32'h0,        16'h0,    5'd11, 3, 1'b1, 32'h0000015A};
    vecs[7] = '{"lhwrap", idLH, 32'hFFFFFFFF, 32'h0,       16'h0001, 5'd12, 4, 1'b1, 32'hFFFF9234};
    vecs[8] = '{"shwrap", idSH, 32'h000003FF, 32'h0000BEEF, 16'h0,   5'd13, 2, 1'b0, 32'h0};

    // Reset: outputs forced to 0 even with a pass-through instruction present.
    rst_in = 1'b1; memBusy_in = 1'b0;
    instIdx_in = idADD; memAddr_in = 32'h40; valStore_in = 32'h0;
    rdE_in = 1'b1; rdIdx_in = 5'd5; rdData_in = 32'h1234;
    #2;
    chk("reset.outs", {stallReq_out, rdE_out, mem_wr_out, rdIdx_out, 24'd0} | rdData_out | mem_a_out, 32'd0);
    @(posedge clk_in); #1;
    preload(10'h007, 8'h80);
    preload(10'h201, 8'h11);
    preload(10'h202, 8'h22);
    preload(10'h203, 8'h33);
    preload(10'h204, 8'h44);
    preload(10'h011, 8'h01);
    preload(10'h3FF, 8'h34);
    preload(10'h000, 8'h92);
    rst_in = 1'b0;

    for (int i = 0; i < 9; i++)
      run_op(vecs[i].name, vecs[i].op, vecs[i].addr, vecs[i].val, vecs[i].busy, 1'b1,
             vecs[i].idx, vecs[i].val, vecs[i].exp_stall, vecs[i].exp_e, vecs[i].exp_data);

    // Reset pulsed mid-load: outputs drop at once, access is abandoned.
    instIdx_in = idLH; memAddr_in = 32'h30; rdIdx_in = 5'd3;
    #4;
    chk("rstmid.stall_before", {31'd0, stallReq_out}, 32'd1);
    @(posedge clk_in); #1;
    rst_in = 1'b1;
    #1;
    chk("rstmid.outs", {stallReq_out, rdE_out, mem_wr_out, rdIdx_out, 24'd0} | rdData_out | mem_a_out, 32'd0);
    @(posedge clk_in); #1;
    instIdx_in = idADD; rdE_in = 1'b1; rdIdx_in = 5'd5; rdData_in = 32'h1234;
    rst_in = 1'b0;
    #3;
    chk("rstmid.add_stall", {31'd0, stallReq_out}, 32'd0);
    chk("rstmid.add_data", rdData_out, 32'h1234);
    chk("rstmid.add_idx", {27'd0, rdIdx_out}, 32'd5);
    @(posedge clk_in); #1;
    run_op("post_rst_lb", idLB, 32'h7, 32'h0, 16'h0, 1'b1, 5'd4, 32'h0, 2, 1'b1, 32'hFFFFFF80);

    // Randomized ops against the model.
    for (int k = 0; k < 60; k++) begin
      logic [3:0]  op;
      logic [31:0] addr, val, rdd, exp_d;
      logic [15:0] busy;
      logic        rde, exp_e;
      logic [4:0]  idx;
      op   = ops[$urandom_range(0, 9)];
      addr = 32'($urandom_range(0, 1023));
      val  = $urandom;
      rdd  = $urandom;
      idx  = 5'($urandom);
      rde  = 1'($urandom);
      busy = 16'($urandom & $urandom) & 16'h00FF;
      if (loads(op)) begin
        exp_d = model_load(op, addr); exp_e = rde;
      end else if (stores(op)) begin
        exp_d = 32'h0; exp_e = 1'b0;
      end else begin
        exp_d = rdd; exp_e = rde;
      end
      run_op($sformatf("rnd%0d", k), op, addr, val, busy, rde, idx, rdd,
             model_stalls(op, busy), exp_e, exp_d);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
